uart_tx_fifo: RTL and testbench

Parametrised UART transmitter with an integrated transmit FIFO, for any block that needs a serial console/debug output port. It supports a configurable frame format: 5-9 data bits, none/odd/even parity, and 1 or 2 stop bits. Upstream writes bytes through a valid/ready handshake. The block serialises them LSB-first on tx, back-to-back, with no idle gap while data is queued.

---
 rtl/uart_tx_fifo.sv | 178 +++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small synchronous FIFO; frames go out LSB-first and
// back-to-back while words are queued. Frame format is fixed at elaboration.
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUDRATE   = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          wr_valid,
    input  logic [DATA_BITS-1:0]          wr_data,
    output logic                          wr_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int T  = CLK_FREQ / BAUDRATE;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (T > 1) ? $clog2(T) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(T - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic [AW:0]   FULL      = (AW + 1)'(FIFO_DEPTH);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_fifo: DATA_BITS must be in 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
    end
    if (T < 2) begin : g_bad_baud
        $error("uart_tx_fifo: CLK_FREQ/BAUDRATE must be at least 2");
    end

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t                 r_state;
    logic [DATA_BITS-1:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0]          r_wptr;
    logic [AW-1:0]          r_rptr;
    logic [AW:0]            r_level;
    logic [CW-1:0]          r_cnt;
    logic [3:0]             r_bit;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_par;
    logic                   r_tx;

    logic                   w_push;
    logic                   w_pop;
    logic                   w_bit_end;
    logic                   w_has_data;
    logic [DATA_BITS-1:0]   w_head;

    assign w_has_data = (r_level != '0);
    assign w_head     = r_mem[r_rptr];
    assign w_bit_end  = (r_cnt == CNT_LAST);
    assign w_push     = wr_valid && wr_ready;
    // A word leaves the FIFO either from IDLE or on the last clock of the final stop bit.
    assign w_pop      = w_has_data &&
                        ((r_state == S_IDLE) ||
                         (r_state == S_STOP && w_bit_end && r_bit == STOP_LAST));

    assign wr_ready   = (r_level != FULL);
    assign busy       = (r_state != S_IDLE) || w_has_data;
    assign fifo_level = r_level;
    assign tx         = r_tx;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Frame word and its parity are frozen at pop, so later writes cannot disturb the frame.
    always_ff @(posedge clk) begin
        if (w_pop) begin
            r_shift <= w_head;
            r_par   <= (PARITY == 1) ? ~^w_head : ^w_head;
        end else if (w_bit_end && (r_state == S_START || r_state == S_DATA)) begin
            r_shift <= r_shift >> 1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_cnt <= (r_state == S_IDLE || w_bit_end) ? '0 : r_cnt + 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_has_data) begin
                        r_state <= S_START;
                        r_tx    <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_state <= S_DATA;
                        r_bit   <= '0;
                        r_tx    <= r_shift[0];
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        if (r_bit == DATA_LAST) begin
                            r_bit <= '0;
                            if (PARITY != 0) begin
                                r_state <= S_PARITY;
                                r_tx    <= r_par;
                            end else begin
                                r_state <= S_STOP;
                                r_tx    <= 1'b1;
                            end
                        end else begin
                            r_bit <= r_bit + 1'b1;
                            r_tx  <= r_shift[0];
                        end
                    end
                end
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_state <= S_STOP;
                        r_bit   <= '0;
                        r_tx    <= 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        if (r_bit == STOP_LAST) begin
                            r_bit <= '0;
                            if (w_has_data) begin
                                r_state <= S_START;
                                r_tx    <= 1'b0;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_bit <= r_bit + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo over three frame formats. The reference model is a timeline:
// each accepted word starts its frame at max(accept edge + 1, previous start + frame length).
module tb_uart_tx_fifo;
    typedef struct {
        logic [8:0] data;
        int         acc;
    } wr_t;

    logic clk = 1'b0;
    int   edge_n = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   n_done = 0;

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic chk(input int g, input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL cfg%0d %s: got %0h, expected %0h (edge %0d)", g, nm, act, exp, edge_n);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : gen_cfg
        localparam int BR    = (g == 0) ? 250_000 : (g == 1) ? 333_333 : 500_000;
        localparam int T     = 1_000_000 / BR;
        localparam int DB    = (g == 0) ? 8 : (g == 1) ? 7 : 9;
        localparam int PAR   = (g == 0) ? 1 : (g == 1) ? 2 : 0;
        localparam int SB    = (g == 1) ? 2 : 1;
        localparam int DEPTH = (g == 2) ? 8 : 4;
        localparam int LW    = $clog2(DEPTH) + 1;
        localparam int NBITS = 1 + DB + ((PAR != 0) ? 1 : 0) + SB;
        localparam int FL    = T * NBITS;
        localparam int LIMIT = FL * (DEPTH + 3) + 20;

        logic          rst_n;
        logic          wr_valid;
        logic [DB-1:0] wr_data;
        logic          wr_ready;
        logic          tx;
        logic          busy;
        logic [LW-1:0] level;
        wr_t           sb_q[$];

        uart_tx_fifo #(
            .CLK_FREQ  (1_000_000),
            .BAUDRATE  (BR),
            .DATA_BITS (DB),
            .PARITY    (PAR),
            .STOP_BITS (SB),
            .FIFO_DEPTH(DEPTH)
        ) u_dut (
            .clk       (clk),
            .reset_n   (rst_n),
            .wr_valid  (wr_valid),
            .wr_data   (wr_data),
            .wr_ready  (wr_ready),
            .tx        (tx),
            .busy      (busy),
            .fifo_level(level)
        );

        // Line bits in transmit order, bit 0 first: start, data LSB-first, parity, stops.
        function automatic logic [NBITS-1:0] frame_of(input logic [8:0] w);
            int   ones;
            logic pbit;
            ones = $countones(w[DB-1:0]);
            pbit = (PAR == 2) ? (ones % 2 == 1) : (ones % 2 == 0);
            if (PAR != 0) return NBITS'({{SB{1'b1}}, pbit, w[DB-1:0], 1'b0});
            return NBITS'({{SB{1'b1}}, w[DB-1:0], 1'b0});
        endfunction

        task automatic put(input logic [8:0] d);
            @(negedge clk);
            wr_valid = 1'b1;
            wr_data  = DB'(d);
            if (wr_ready) sb_q.push_back('{9'(wr_data), edge_n + 1});
        endtask

        task automatic idle_cycles(input int n);
            for (int c = 0; c < n; c++) begin
                @(negedge clk);
                wr_valid = 1'b0;
            end
        endtask

        task automatic traffic(input int n, input int pct, input bit count_up);
            logic [8:0] nxt;
            nxt = '0;
            for (int c = 0; c < n; c++) begin
                @(negedge clk);
                wr_valid = ($urandom_range(99) < pct);
                wr_data  = count_up ? DB'(nxt) : DB'($urandom);
                if (wr_valid && wr_ready) begin
                    sb_q.push_back('{9'(wr_data), edge_n + 1});
                    nxt = nxt + 9'd1;
                end
            end
        endtask

        task automatic wait_idle();
            int c;
            c = 0;
            @(negedge clk);
            wr_valid = 1'b0;
            while (busy && c < LIMIT) begin
                @(negedge clk);
                c++;
            end
            chk(g, "idle_timeout", 32'(busy), 32'd0);
        endtask

        task automatic mid_reset();
            wait_idle();
            for (int i = 0; i < 4; i++) put(9'($urandom));
            idle_cycles(3 * T);
            #2 rst_n = 1'b0;
            sb_q.delete();
            #1;
            chk(g, "async_rst_tx", 32'(tx), 32'd1);
            chk(g, "async_rst_busy", 32'(busy), 32'd0);
            chk(g, "async_rst_level", 32'(level), 32'd0);
            chk(g, "async_rst_ready", 32'(wr_ready), 32'd1);
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            put(9'h055);
            wait_idle();
        endtask

        initial begin : stim
            int e0;
            rst_n    = 1'b0;
            wr_valid = 1'b0;
            wr_data  = '0;
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
            idle_cycles(2);
            put(9'h041);
            wait_idle();
            put(9'h07F);
            wait_idle();
            traffic(DEPTH + 12, 100, 1'b1);
            wait_idle();
            // Two words from idle leave one queued; a third arrives on the edge the first frame ends.
            put(9'h0A5);
            e0 = edge_n + 1;
            put(9'h03C);
            while (edge_n < e0 + FL - 1) begin
                @(negedge clk);
                wr_valid = 1'b0;
            end
            put(9'h0C3);
            wait_idle();
            mid_reset();
            traffic(600, 30, 1'b0);
            traffic(600, 80, 1'b0);
            traffic(300, 100, 1'b0);
            wait_idle();
            mid_reset();
            traffic(400, 60, 1'b0);
            wait_idle();
            idle_cycles(4);
            n_done++;
        end

        initial begin : mon
            wr_t            pend[$];
            wr_t            w;
            int             s_cur;
            bit             cur_v;
            logic [NBITS-1:0] fr;
            logic [NBITS-1:0] sh;
            logic           exp_tx;
            s_cur = 0;
            cur_v = 1'b0;
            fr    = '1;
            forever begin
                @(posedge clk);
                #1;
                if (!rst_n) begin
                    pend.delete();
                    cur_v = 1'b0;
                    chk(g, "rst_tx", 32'(tx), 32'd1);
                    chk(g, "rst_busy", 32'(busy), 32'd0);
                    chk(g, "rst_level", 32'(level), 32'd0);
                    chk(g, "rst_ready", 32'(wr_ready), 32'd1);
                end else begin
                    while (sb_q.size() > 0 && sb_q[0].acc <= edge_n) pend.push_back(sb_q.pop_front());
                    if (cur_v && edge_n >= s_cur + FL) cur_v = 1'b0;
                    if (!cur_v && pend.size() > 0 && edge_n > pend[0].acc) begin
                        w     = pend.pop_front();
                        fr    = frame_of(w.data);
                        s_cur = edge_n;
                        cur_v = 1'b1;
                    end
                    exp_tx = 1'b1;
                    if (cur_v) begin
                        sh     = fr >> ((edge_n - s_cur) / T);
                        exp_tx = sh[0];
                    end
                    chk(g, "tx", 32'(tx), 32'(exp_tx));
                    chk(g, "fifo_level", 32'(level), 32'(pend.size()));
                    chk(g, "busy", 32'(busy), 32'(cur_v || pend.size() != 0));
                    chk(g, "wr_ready", 32'(wr_ready), 32'(pend.size() < DEPTH));
                end
            end
        end
    end

    initial begin : main
        for (int c = 0; c < 60000 && n_done < 3; c++) @(posedge clk);
        n_vec++;
        if (n_done < 3) begin
            n_err++;
            $display("FAIL completion: %0d configurations finished, expected 3", n_done);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
